// File: rtl/blank_mapper_ml_if.sv
// Blanking-symbol mapper bus bundle.
//
// Groups the scheduler-side inputs and the lane-steering outputs of
// blank_mapper_ml so they travel as one port.
//   master : scheduler / secondary-data side (drives sched_*, td_*, sec_*)
//   slave  : the mapper itself (drives blank_*)
//
// Signals:
//   sched_blank_en          blanking phase active
//   sched_blank_id          1 = HBlank, 0 = VBlank
//   sched_blank_state       00 blank/dummy, 01 BS, 10 start block, 11 BE
//   td_lane_count           active lanes: 00 = 1, 01 = 2, 11 = 4 (10 illegal)
//   sec_steered_out         secondary data, lane i at [i*SYM_W +: SYM_W]
//   sec_steered_vld         MSA byte valid
//   blank_steering_state    00 idle, 01 sequence hand-off, 10 MSA in progress
//   blank_control_sym_flag  per-lane K-symbol flag
//   blank_symbols           per-lane symbol
//   blank_seq_done          pulse with the last symbol of BS / start / BE
//   blank_lane_err          sticky illegal-lane-count flag
interface blank_mapper_ml_if #(
  parameter int unsigned LANES = 4,
  parameter int unsigned SYM_W = 8
);
  logic                   sched_blank_en;
  logic                   sched_blank_id;
  logic [1:0]             sched_blank_state;
  logic [1:0]             td_lane_count;
  logic [LANES*SYM_W-1:0] sec_steered_out;
  logic                   sec_steered_vld;
  logic [1:0]             blank_steering_state;
  logic [LANES-1:0]       blank_control_sym_flag;
  logic [LANES*SYM_W-1:0] blank_symbols;
  logic                   blank_seq_done;
  logic                   blank_lane_err;

  modport master (
    output sched_blank_en,
    output sched_blank_id,
    output sched_blank_state,
    output td_lane_count,
    output sec_steered_out,
    output sec_steered_vld,
    input  blank_steering_state,
    input  blank_control_sym_flag,
    input  blank_symbols,
    input  blank_seq_done,
    input  blank_lane_err
  );

  modport slave (
    input  sched_blank_en,
    input  sched_blank_id,
    input  sched_blank_state,
    input  td_lane_count,
    input  sec_steered_out,
    input  sec_steered_vld,
    output blank_steering_state,
    output blank_control_sym_flag,
    output blank_symbols,
    output blank_seq_done,
    output blank_lane_err
  );
endinterface

// File: rtl/blank_mapper_ml.sv
// Multi-lane blanking-symbol generator for the main-link path.
//
// Sits between the stream scheduler and lane steering. For each scheduled
// blanking phase it emits per-lane symbols for BS/BF framing, the
// VB-ID/Mvid/Maud start block, the first-VBlank SS/MSA/SE packet and BE
// framing. All outputs are registered (one cycle after the sampled inputs);
// lanes at or above the active lane count are forced to zero.
//
// Ports:
//   clk  main-link symbol clock, rising edge
//   rst  synchronous, active-high reset
//   bus  blank_mapper_ml_if.slave (scheduler inputs, steering outputs)
//
// Build option:
//   BLANK_SR_EN  when defined, a 9-bit count of completed BS sequences is
//                kept and every 512th BS sequence carries SR (0x1C) in place
//                of both BS symbols. Undefined: BS is always 0xBC.
module blank_mapper_ml #(
  parameter int unsigned LANES   = 4,
  parameter int unsigned SYM_W   = 8,
  parameter int unsigned MSA_MAX = 40
) (
  input logic              clk,
  input logic              rst,
  blank_mapper_ml_if.slave bus
);

  localparam int unsigned PayW = $clog2(MSA_MAX + 1);

  localparam logic [SYM_W-1:0] SymBs = SYM_W'(8'hBC);
  localparam logic [SYM_W-1:0] SymBf = SYM_W'(8'hBD);
  localparam logic [SYM_W-1:0] SymBe = SYM_W'(8'hBE);
  localparam logic [SYM_W-1:0] SymSs = SYM_W'(8'hDC);
  localparam logic [SYM_W-1:0] SymSe = SYM_W'(8'hDE);
  localparam logic [SYM_W-1:0] SymSr = SYM_W'(8'h1C);

  localparam logic [1:0] StateBlank = 2'b00;
  localparam logic [1:0] StateBs    = 2'b01;
  localparam logic [1:0] StateStart = 2'b10;
  localparam logic [1:0] StateBe    = 2'b11;

  localparam logic [1:0] SteerIdle = 2'b00;
  localparam logic [1:0] SteerHand = 2'b01;
  localparam logic [1:0] SteerMsa  = 2'b10;

  typedef enum logic [1:0] {StSs1, StSs2, StPay, StDone} msa_st_e;

  // State
  logic [1:0]             bs_cnt_q, bs_cnt_d;
  logic [3:0]             st_cnt_q, st_cnt_d;
  logic [1:0]             be_cnt_q, be_cnt_d;
  msa_st_e                msa_st_q, msa_st_d;
  logic [PayW-1:0]        pay_cnt_q, pay_cnt_d;
  logic                   err_q, err_d;

  // Registered outputs
  logic [LANES*SYM_W-1:0] sym_q, sym_d;
  logic [LANES-1:0]       flag_q, flag_d;
  logic [1:0]             steer_q, steer_d;
  logic                   done_q, done_d;

  // Decoded lane configuration
  logic [2:0]             n_lanes;
  logic [3:0]             seq_len;
  logic                   lane_illegal;
  logic [LANES-1:0]       lane_act;

  // Start-block position
  logic [3:0]             st_eff;
  logic [1:0]             st_phase;

  // Common symbol broadcast to all active lanes, or per-lane pass-through
  logic [SYM_W-1:0]       sym_c;
  logic                   flag_c;
  logic                   pass_c;

  logic                   sr_hit;
  logic                   sr_inc;

  // seq_len is the start-block length 3R with R = 4/N.
  always_comb begin
    n_lanes      = 3'd1;
    seq_len      = 4'd12;
    lane_illegal = 1'b0;
    unique case (bus.td_lane_count)
      2'b00: begin
        n_lanes = 3'd1;
        seq_len = 4'd12;
      end
      2'b01: begin
        n_lanes = 3'd2;
        seq_len = 4'd6;
      end
      2'b11: begin
        n_lanes = 3'd4;
        seq_len = 4'd3;
      end
      default: begin
        n_lanes      = 3'd1;
        seq_len      = 4'd12;
        lane_illegal = 1'b1;
      end
    endcase
  end

  always_comb begin
    lane_act = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      lane_act[i] = (i < int'(n_lanes));
    end
  end

  // A lane-count change can shrink the block under a running counter; a
  // position beyond the new end restarts the block.
  assign st_eff   = (st_cnt_q >= seq_len) ? 4'd0 : st_cnt_q;
  assign st_phase = 2'(st_eff % 4'd3);

`ifdef BLANK_SR_EN
  logic [8:0] sr_cnt_q;

  assign sr_hit = (sr_cnt_q == 9'h1FF);

  // Held across disabled phases and sequence switches; only rst clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_cnt_q <= '0;
    end else if (sr_inc) begin
      sr_cnt_q <= sr_cnt_q + 9'd1;
    end
  end
`else
  logic unused_sr_inc;

  assign sr_hit        = 1'b0;
  assign unused_sr_inc = sr_inc;
`endif

  always_comb begin
    sym_c     = '0;
    flag_c    = 1'b0;
    pass_c    = 1'b0;
    steer_d   = SteerIdle;
    done_d    = 1'b0;
    sr_inc    = 1'b0;
    // Sequence counters restart unless their own sequence is running.
    bs_cnt_d  = '0;
    st_cnt_d  = '0;
    be_cnt_d  = '0;
    // The MSA tracker only moves during blank phases.
    msa_st_d  = msa_st_q;
    pay_cnt_d = pay_cnt_q;
    err_d     = err_q | (bus.sched_blank_en & lane_illegal);

    if (bus.sched_blank_en) begin
      unique case (bus.sched_blank_state)
        StateBs: begin
          flag_c   = 1'b1;
          sym_c    = ((bs_cnt_q == 2'd0) || (bs_cnt_q == 2'd3)) ? (sr_hit ? SymSr : SymBs) : SymBf;
          bs_cnt_d = bs_cnt_q + 2'd1;
          if (bs_cnt_q == 2'd3) begin
            steer_d = SteerHand;
            done_d  = 1'b1;
            sr_inc  = 1'b1;
          end
        end

        StateStart: begin
          unique case (st_phase)
            2'd0:    sym_c = SYM_W'(!bus.sched_blank_id);  // VB-ID: 1 only in VBlank
            2'd1:    sym_c = bus.sec_steered_out[SYM_W-1:0];  // Mvid from lane 0
            default: sym_c = '0;  // Maud
          endcase
          if (st_eff == 4'(seq_len - 4'd1)) begin
            steer_d  = SteerHand;
            done_d   = 1'b1;
            st_cnt_d = '0;
          end else begin
            st_cnt_d = st_eff + 4'd1;
          end
        end

        StateBe: begin
          flag_c   = 1'b1;
          sym_c    = ((be_cnt_q == 2'd0) || (be_cnt_q == 2'd3)) ? SymBe : SymBf;
          be_cnt_d = be_cnt_q + 2'd1;
          if (be_cnt_q == 2'd3) begin
            done_d = 1'b1;
          end
        end

        default: begin
          if (bus.sched_blank_id) begin
            // HBlank dummy: re-arm the MSA packet for the next VBlank.
            msa_st_d  = StSs1;
            pay_cnt_d = '0;
          end else begin
            unique case (msa_st_q)
              StSs1: begin
                sym_c    = SymSs;
                flag_c   = 1'b1;
                steer_d  = SteerMsa;
                msa_st_d = StSs2;
              end
              StSs2: begin
                sym_c    = SymSs;
                flag_c   = 1'b1;
                steer_d  = SteerMsa;
                msa_st_d = StPay;
              end
              StPay: begin
                if (bus.sec_steered_vld && (pay_cnt_q < PayW'(MSA_MAX))) begin
                  pass_c    = 1'b1;
                  steer_d   = SteerMsa;
                  pay_cnt_d = pay_cnt_q + PayW'(1);
                end else begin
                  // End of payload or timeout: close the packet with SE.
                  sym_c    = SymSe;
                  flag_c   = 1'b1;
                  msa_st_d = StDone;
                end
              end
              StDone: begin
                sym_c = '0;
              end
            endcase
          end
        end
      endcase
    end
  end

  always_comb begin
    sym_d  = '0;
    flag_d = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      if (lane_act[i]) begin
        sym_d[i*SYM_W +: SYM_W] = pass_c ? bus.sec_steered_out[i*SYM_W +: SYM_W] : sym_c;
        flag_d[i]               = flag_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bs_cnt_q  <= '0;
      st_cnt_q  <= '0;
      be_cnt_q  <= '0;
      msa_st_q  <= StSs1;
      pay_cnt_q <= '0;
      err_q     <= 1'b0;
      sym_q     <= '0;
      flag_q    <= '0;
      steer_q   <= SteerIdle;
      done_q    <= 1'b0;
    end else begin
      bs_cnt_q  <= bs_cnt_d;
      st_cnt_q  <= st_cnt_d;
      be_cnt_q  <= be_cnt_d;
      msa_st_q  <= msa_st_d;
      pay_cnt_q <= pay_cnt_d;
      err_q     <= err_d;
      sym_q     <= sym_d;
      flag_q    <= flag_d;
      steer_q   <= steer_d;
      done_q    <= done_d;
    end
  end

  assign bus.blank_symbols          = sym_q;
  assign bus.blank_control_sym_flag = flag_q;
  assign bus.blank_steering_state   = steer_q;
  assign bus.blank_seq_done         = done_q;
  assign bus.blank_lane_err         = err_q;

endmodule

// File: tb/tb_blank_mapper_ml.sv
// Self-checking bench for blank_mapper_ml: directed scenarios followed by
// randomized phases, all compared cycle by cycle with a behavioural model.
module tb_blank_mapper_ml;

  localparam int Lanes  = 4;
  localparam int SymW   = 8;
  localparam int MsaMax = 40;

  logic clk;
  logic rst;

  blank_mapper_ml_if #(.LANES(Lanes), .SYM_W(SymW)) bus ();

  blank_mapper_ml #(
    .LANES  (Lanes),
    .SYM_W  (SymW),
    .MSA_MAX(MsaMax)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_bad;

  // Model state: current run of a scheduled sequence, start-block position,
  // MSA packet progress, completed BS count and the sticky error.
  int run_kind;
  int run_len;
  int st_idx;
  int msa_n;
  bit msa_end;
  int bs_seqs;
  bit m_err;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic bit sr_due();
`ifdef BLANK_SR_EN
    return (bs_seqs % 512) == 511;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [1:0] pick_lc();
    int v;
    v = $urandom_range(0, 15);
    if (v == 0) return 2'b10;
    if (v < 6) return 2'b00;
    if (v < 11) return 2'b01;
    return 2'b11;
  endfunction

  task automatic model_clear();
    run_kind = -1;
    run_len  = 0;
    st_idx   = 0;
    msa_n    = 0;
    msa_end  = 1'b0;
    bs_seqs  = 0;
    m_err    = 1'b0;
  endtask

  task automatic do_reset();
    rst                   = 1'b1;
    bus.sched_blank_en    = 1'b0;
    bus.sched_blank_id    = 1'b0;
    bus.sched_blank_state = 2'b00;
    bus.td_lane_count     = 2'b11;
    bus.sec_steered_out   = '0;
    bus.sec_steered_vld   = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check_eq("rst_symbols", 64'(bus.blank_symbols), 64'h0);
    check_eq("rst_flags", 64'(bus.blank_control_sym_flag), 64'h0);
    check_eq("rst_steer", 64'(bus.blank_steering_state), 64'h0);
    check_eq("rst_done", 64'(bus.blank_seq_done), 64'h0);
    check_eq("rst_lane_err", 64'(bus.blank_lane_err), 64'h0);
    rst = 1'b0;
    model_clear();
  endtask

  // Drive one cycle of inputs, predict the registered outputs, compare after the edge.
  task automatic step(input bit en, input bit id, input logic [1:0] st, input logic [1:0] lc,
                      input logic [31:0] data, input bit vld);
    int         n;
    int         len;
    int         kind;
    int         p;
    logic [7:0] sc;
    bit         fc;
    bit         pass;
    bit         dn;
    logic [1:0] steer;
    logic [31:0] esym;
    logic [3:0]  eflag;

    bus.sched_blank_en    = en;
    bus.sched_blank_id    = id;
    bus.sched_blank_state = st;
    bus.td_lane_count     = lc;
    bus.sec_steered_out   = data;
    bus.sec_steered_vld   = vld;

    n     = (lc == 2'b01) ? 2 : (lc == 2'b11) ? 4 : 1;
    len   = 3 * (4 / n);
    kind  = en ? int'(st) : -1;
    sc    = 8'h00;
    fc    = 1'b0;
    pass  = 1'b0;
    dn    = 1'b0;
    steer = 2'b00;

    if (en && lc == 2'b10) m_err = 1'b1;
    if (kind != run_kind) begin
      run_len = 0;
      st_idx  = 0;
    end
    run_kind = kind;

    case (kind)
      1: begin
        p  = run_len % 4;
        fc = 1'b1;
        if (p == 0 || p == 3) sc = sr_due() ? 8'h1C : 8'hBC;
        else sc = 8'hBD;
        if (p == 3) begin
          dn    = 1'b1;
          steer = 2'b01;
          bs_seqs++;
        end
        run_len++;
      end
      2: begin
        if (st_idx >= len) st_idx = 0;
        case (st_idx % 3)
          0:       sc = id ? 8'h00 : 8'h01;
          1:       sc = data[7:0];
          default: sc = 8'h00;
        endcase
        if (st_idx == len - 1) begin
          dn    = 1'b1;
          steer = 2'b01;
        end
        st_idx = (st_idx + 1) % len;
      end
      3: begin
        p  = run_len % 4;
        fc = 1'b1;
        sc = (p == 0 || p == 3) ? 8'hBE : 8'hBD;
        if (p == 3) dn = 1'b1;
        run_len++;
      end
      0: begin
        if (id) begin
          msa_n   = 0;
          msa_end = 1'b0;
        end else if (!msa_end) begin
          if (msa_n < 2) begin
            sc    = 8'hDC;
            fc    = 1'b1;
            steer = 2'b10;
            msa_n++;
          end else if (vld && (msa_n - 2) < MsaMax) begin
            pass  = 1'b1;
            steer = 2'b10;
            msa_n++;
          end else begin
            sc      = 8'hDE;
            fc      = 1'b1;
            msa_end = 1'b1;
          end
        end
      end
      default: ;
    endcase

    esym  = '0;
    eflag = '0;
    for (int i = 0; i < Lanes; i++) begin
      if (i < n) begin
        esym[i*8 +: 8] = pass ? data[i*8 +: 8] : sc;
        eflag[i]       = fc;
      end
    end

    @(posedge clk);
    #1;
    check_eq("symbols", 64'(bus.blank_symbols), 64'(esym));
    check_eq("flags", 64'(bus.blank_control_sym_flag), 64'(eflag));
    check_eq("steer", 64'(bus.blank_steering_state), 64'(steer));
    check_eq("done", 64'(bus.blank_seq_done), 64'(dn));
    check_eq("lane_err", 64'(bus.blank_lane_err), 64'(m_err));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [1:0] lc;
    logic [1:0] st;
    bit         en;
    bit         id;
    int         len;

    n_checks = 0;
    n_bad    = 0;
    model_clear();
    do_reset();

    // BS on 4 lanes.
    step(1, 1, 2'b01, 2'b11, 32'h0, 0);
    check_eq("bs_first_sym", 64'(bus.blank_symbols), 64'hBCBC_BCBC);
    for (int k = 0; k < 3; k++) step(1, 1, 2'b01, 2'b11, 32'h0, 0);

    // VBlank start block on 2 lanes.
    step(1, 0, 2'b10, 2'b01, 32'h1234_565A, 0);
    check_eq("start_vbid", 64'(bus.blank_symbols), 64'h0000_0101);
    step(1, 0, 2'b10, 2'b01, 32'h1234_565A, 0);
    check_eq("start_mvid", 64'(bus.blank_symbols), 64'h0000_5A5A);
    for (int k = 0; k < 4; k++) step(1, 0, 2'b10, 2'b01, 32'h1234_565A, 0);

    // Lane-count shrink mid start block: position 8 of 12 restarts at 0 of 6.
    for (int k = 0; k < 8; k++) step(1, 1, 2'b10, 2'b00, $urandom, 0);
    for (int k = 0; k < 4; k++) step(1, 1, 2'b10, 2'b01, $urandom, 0);

    // BE framing.
    for (int k = 0; k < 5; k++) step(1, 0, 2'b11, 2'b11, 32'h0, 0);

    // MSA with timeout: SS, SS, 40 payload, SE, then dummy.
    for (int k = 0; k < 46; k++) step(1, 0, 2'b00, 2'b11, $urandom, 1);

    // HBlank clears the tracker; the next VBlank blank restarts at SS.
    step(1, 1, 2'b00, 2'b11, 32'h0, 0);
    step(1, 0, 2'b00, 2'b11, 32'h0, 1);
    check_eq("msa_restart", 64'(bus.blank_symbols), 64'hDCDC_DCDC);
    for (int k = 0; k < 5; k++) step(1, 0, 2'b00, 2'b11, $urandom, $urandom_range(0, 3) != 0);

    // Illegal lane count: single-lane 12-cycle start block, sticky error.
    for (int k = 0; k < 14; k++) step(1, 0, 2'b10, 2'b10, $urandom, 0);
    for (int k = 0; k < 4; k++) step(1, 1, 2'b01, 2'b11, 32'h0, 0);
    check_eq("err_sticky", 64'(bus.blank_lane_err), 64'h1);
    do_reset();

    // 513 BS sequences (SR on the 512th when enabled).
    for (int k = 0; k < 513 * 4; k++) step(1, 1, 2'b01, 2'b11, 32'h0, 0);

    // Randomized phases.
    repeat (300) begin
      if ($urandom_range(0, 40) == 0) do_reset();
      en  = $urandom_range(0, 9) != 0;
      st  = 2'($urandom_range(0, 3));
      id  = 1'($urandom_range(0, 1));
      lc  = pick_lc();
      len = $urandom_range(1, 16);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 9) == 0) lc = pick_lc();
        step(en, id, st, lc, $urandom, $urandom_range(0, 7) != 0);
      end
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
